// File: rtl/wptr_handler.sv
// Async FIFO write-side pointer and flag logic.
// Binary/Gray write pointers, full/almost_full/level from the synced read pointer.
module wptr_handler #(
  parameter int PTR_SIZE  = 3,
  parameter int AF_THRESH = 6
) (
  input  logic                w_clk,
  input  logic                wrst,
  input  logic                w_en,
  input  logic [PTR_SIZE:0]   g_rptr_sync,
  input  logic                ovf_clr,
  output logic                w_ack,
  output logic [PTR_SIZE:0]   b_wptr,
  output logic [PTR_SIZE:0]   g_wptr,
  output logic                full,
  output logic                almost_full,
  output logic [PTR_SIZE:0]   w_level,
  output logic                overflow
);

  localparam logic [PTR_SIZE:0] AF_T = (PTR_SIZE+1)'(AF_THRESH);

  logic [PTR_SIZE:0] b_wptr_next;
  logic [PTR_SIZE:0] g_wptr_next;
  logic [PTR_SIZE:0] rbin;
  logic [PTR_SIZE:0] lvl_next;
  logic [PTR_SIZE:0] full_cmp;

  // Held off during reset so the memory never sees a write while state is discarded.
  assign w_ack = w_en & ~full & ~wrst;

  assign b_wptr_next = b_wptr + {{PTR_SIZE{1'b0}}, w_ack};
  assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

  for (genvar i = 0; i <= PTR_SIZE; i++) begin : g_g2b
    assign rbin[i] = ^g_rptr_sync[PTR_SIZE:i];
  end

  assign lvl_next = b_wptr_next - rbin;
  assign full_cmp = {~g_rptr_sync[PTR_SIZE:PTR_SIZE-1],
                     g_rptr_sync[PTR_SIZE-2:0]};

  always_ff @(posedge w_clk) begin
    if (wrst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= (g_wptr_next == full_cmp);
      almost_full <= (lvl_next >= AF_T);
      w_level     <= lvl_next;
      // Set wins over clear.
      if (w_en && full)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_handler.sv
// Directed testbench for wptr_handler (PTR_SIZE=3, AF_THRESH=6).
// Each scenario task drives stimulus and checks inline.
module tb_wptr_handler;

  logic       w_clk = 1'b0;
  logic       wrst;
  logic       w_en;
  logic [3:0] g_rptr_sync;
  logic       ovf_clr;
  logic       w_ack;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] w_level;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  wptr_handler #(.PTR_SIZE(3), .AF_THRESH(6)) dut (
    .w_clk(w_clk),
    .wrst(wrst),
    .w_en(w_en),
    .g_rptr_sync(g_rptr_sync),
    .ovf_clr(ovf_clr),
    .w_ack(w_ack),
    .b_wptr(b_wptr),
    .g_wptr(g_wptr),
    .full(full),
    .almost_full(almost_full),
    .w_level(w_level),
    .overflow(overflow)
  );

  always #5 w_clk = ~w_clk;

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1; w_en = 1'b1; g_rptr_sync = 4'd0; ovf_clr = 1'b0;
    step();
    step();
    checks++;
    if (w_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack: got %b want 0", w_ack);
    end
    checks++;
    if ({b_wptr, g_wptr, w_level} !== 12'd0 ||
        {full, almost_full, overflow} !== 3'b000) begin
      errors++;
      $display("FAIL rst_state: b=%h g=%h l=%h f=%b af=%b ov=%b want all 0",
               b_wptr, g_wptr, w_level, full, almost_full, overflow);
    end
    w_en = 1'b0;
    wrst = 1'b0;
    #1;
    checks++;
    if (w_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack_idle: got %b want 0", w_ack);
    end
    w_en = 1'b1;
    #1;
    checks++;
    if (w_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_ack_rel: got %b want 1", w_ack);
    end
  endtask

  task automatic test_fill();
    logic [3:0] gx;
    g_rptr_sync = 4'd0; w_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      gx = 4'(i) ^ (4'(i) >> 1);
      checks++;
      if (b_wptr !== 4'(i) || g_wptr !== gx || w_level !== 4'(i)) begin
        errors++;
        $display("FAIL fill_ptr%0d: b=%h g=%h l=%h want b=%h g=%h l=%h",
                 i, b_wptr, g_wptr, w_level, 4'(i), gx, 4'(i));
      end
      checks++;
      if (almost_full !== (i >= 6) || full !== (i == 8)) begin
        errors++;
        $display("FAIL fill_flag%0d: af=%b f=%b want af=%b f=%b",
                 i, almost_full, full, (i >= 6), (i == 8));
      end
    end
    checks++;
    if (w_ack !== 1'b0) begin
      errors++;
      $display("FAIL fill_ack9: got %b want 0", w_ack);
    end
    step();
    checks++;
    if (b_wptr !== 4'd8 || g_wptr !== 4'b1100 || overflow !== 1'b1 ||
        full !== 1'b1) begin
      errors++;
      $display("FAIL fill_ovf: b=%h g=%b ov=%b f=%b want 8 1100 1 1",
               b_wptr, g_wptr, overflow, full);
    end
  endtask

  task automatic test_drain();
    w_en = 1'b0;
    g_rptr_sync = 4'b0110;
    step();
    checks++;
    if (full !== 1'b0 || w_level !== 4'd4 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL drain: f=%b l=%0d af=%b want 0 4 0",
               full, w_level, almost_full);
    end
  endtask

  task automatic test_wrap();
    w_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (b_wptr !== 4'd12 || full !== 1'b1 || w_level !== 4'd8) begin
      errors++;
      $display("FAIL wrap_full12: b=%0d f=%b l=%0d want 12 1 8",
               b_wptr, full, w_level);
    end
    w_en = 1'b0;
    g_rptr_sync = 4'b1100;
    step();
    checks++;
    if (full !== 1'b0 || w_level !== 4'd4) begin
      errors++;
      $display("FAIL wrap_free: f=%b l=%0d want 0 4", full, w_level);
    end
    w_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (b_wptr !== 4'b1111 || g_wptr !== 4'b1000 || w_level !== 4'd7 ||
        full !== 1'b0 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_15: b=%b g=%b l=%0d f=%b af=%b want 1111 1000 7 0 1",
               b_wptr, g_wptr, w_level, full, almost_full);
    end
    step();
    checks++;
    if (b_wptr !== 4'd0 || g_wptr !== 4'd0 || w_level !== 4'd8 ||
        full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_0: b=%b g=%b l=%0d f=%b want 0000 0000 8 1",
               b_wptr, g_wptr, w_level, full);
    end
    g_rptr_sync = 4'b1101;
    #1;
    checks++;
    if (w_ack !== 1'b0) begin
      errors++;
      $display("FAIL simul_ack: got %b want 0", w_ack);
    end
    step();
    checks++;
    if (full !== 1'b0 || b_wptr !== 4'd0 || w_level !== 4'd7 ||
        w_ack !== 1'b1) begin
      errors++;
      $display("FAIL simul_drop: f=%b b=%0d l=%0d ack=%b want 0 0 7 1",
               full, b_wptr, w_level, w_ack);
    end
    step();
    checks++;
    if (b_wptr !== 4'd1 || full !== 1'b1 || w_level !== 4'd8) begin
      errors++;
      $display("FAIL simul_acc: b=%0d f=%b l=%0d want 1 1 8",
               b_wptr, full, w_level);
    end
  endtask

  task automatic test_overflow();
    w_en = 1'b1; ovf_clr = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    w_en = 1'b0;
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", overflow);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_midop_reset();
    w_en = 1'b1;
    step();
    w_en = 1'b0;
    g_rptr_sync = 4'b1010;
    step();
    checks++;
    if (w_level !== 4'd5 || overflow !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: l=%0d ov=%b f=%b want 5 1 0",
               w_level, overflow, full);
    end
    wrst = 1'b1; w_en = 1'b1;
    step();
    checks++;
    if ({b_wptr, g_wptr, w_level} !== 12'd0 ||
        {full, almost_full, overflow} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst: b=%h g=%h l=%h f=%b af=%b ov=%b want all 0",
               b_wptr, g_wptr, w_level, full, almost_full, overflow);
    end
    wrst = 1'b0;
    g_rptr_sync = 4'd0;
    step();
    step();
    checks++;
    if (b_wptr !== 4'd2 || g_wptr !== 4'b0011 || w_level !== 4'd2) begin
      errors++;
      $display("FAIL mid_resume: b=%0d g=%b l=%0d want 2 0011 2",
               b_wptr, g_wptr, w_level);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_overflow();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
